reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for all PLLs to lock, holds, then releases
// the downstream reset stages one by one and watches for debounced lock loss.
module reset_sequencer #(
  parameter int LOCK_W      = 2,
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int DEBOUNCE    = 3,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [LOCK_W-1:0] lock,
  input  logic              sw_req,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic              timeout,
  output logic [CNT_W-1:0]  loss_count
);

  localparam int MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_C = (MAX_A > DEBOUNCE) ? MAX_A : DEBOUNCE;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST     = CW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STAGE_LAST   = SW'(STAGES - 1);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

  // Asserts immediately with resetn, releases two clk edges after it rises.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_reg <= 2'b00;
    else         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n = rst_sync_reg[1];

  logic [LOCK_W-1:0] lock_sync;
  logic              all_locked;

  genvar gi;
  generate
    for (gi = 0; gi < LOCK_W; gi++) begin : g_lock_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= lock[gi];
          sync_reg <= meta_reg;
        end
      end
      assign lock_sync[gi] = sync_reg;
    end
  endgenerate

  assign all_locked = &lock_sync;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [TW-1:0]     wait_reg, wait_next;
  logic [SW-1:0]     stage_reg, stage_next;
  logic [STAGES-1:0] rst_out_reg, rst_out_next;
  logic              ready_reg, ready_next;
  logic              timeout_reg, timeout_next;
  logic [CNT_W-1:0]  loss_reg, loss_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= WAIT_LOCK;
      cnt_reg     <= '0;
      wait_reg    <= '0;
      stage_reg   <= '0;
      rst_out_reg <= '1;
      ready_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      loss_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wait_reg    <= wait_next;
      stage_reg   <= stage_next;
      rst_out_reg <= rst_out_next;
      ready_reg   <= ready_next;
      timeout_reg <= timeout_next;
      loss_reg    <= loss_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    wait_next    = '0;
    stage_next   = stage_reg;
    rst_out_next = rst_out_reg;
    ready_next   = ready_reg;
    timeout_next = timeout_reg;
    loss_next    = loss_reg;

    case (state_reg)
      WAIT_LOCK: begin
        rst_out_next = '1;
        ready_next   = 1'b0;
        cnt_next     = '0;
        stage_next   = '0;
        if (all_locked) begin
          state_next   = HOLD;
          timeout_next = 1'b0;
        end else if (!timeout_reg) begin
          wait_next = wait_reg + 1'b1;
          if (wait_reg == TIMEOUT_LAST) timeout_next = 1'b1;
        end else begin
          wait_next = wait_reg;
        end
      end

      HOLD: begin
        if (!all_locked) begin
          state_next   = WAIT_LOCK;
          rst_out_next = '1;
          cnt_next     = '0;
        end else if (sw_req) begin
          cnt_next = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          cnt_next        = '0;
          rst_out_next[0] = 1'b0;
          if (STAGES == 1) begin
            state_next = RUN;
            ready_next = 1'b1;
          end else begin
            state_next = RELEASE;
            stage_next = SW'(1);
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RELEASE: begin
        if (!all_locked) begin
          state_next   = WAIT_LOCK;
          rst_out_next = '1;
          cnt_next     = '0;
          stage_next   = '0;
        end else if (sw_req) begin
          state_next   = HOLD;
          rst_out_next = '1;
          cnt_next     = '0;
          stage_next   = '0;
        end else if (cnt_reg == GAP_LAST) begin
          cnt_next                = '0;
          rst_out_next[stage_reg] = 1'b0;
          if (stage_reg == STAGE_LAST) begin
            state_next = RUN;
            ready_next = 1'b1;
          end else begin
            stage_next = stage_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RUN: begin
        // A debounced loss outranks a simultaneous software request.
        if (!all_locked && cnt_reg == DEB_LAST) begin
          state_next   = WAIT_LOCK;
          rst_out_next = '1;
          ready_next   = 1'b0;
          cnt_next     = '0;
          stage_next   = '0;
          loss_next    = (loss_reg == '1) ? loss_reg : loss_reg + 1'b1;
        end else if (sw_req) begin
          state_next   = HOLD;
          rst_out_next = '1;
          ready_next   = 1'b0;
          cnt_next     = '0;
          stage_next   = '0;
        end else if (!all_locked) begin
          cnt_next = cnt_reg + 1'b1;
        end else begin
          cnt_next = '0;
        end
      end

      default: begin
        state_next   = WAIT_LOCK;
        rst_out_next = '1;
        ready_next   = 1'b0;
        cnt_next     = '0;
        stage_next   = '0;
      end
    endcase
  end

  assign rst_out    = rst_out_reg;
  assign ready      = ready_reg;
  assign timeout    = timeout_reg;
  assign loss_count = loss_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timeline model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_reset_sequencer;

  localparam int LOCK_W  = 2;
  localparam int STAGES  = 3;
  localparam int HOLD    = 16;
  localparam int GAP     = 4;
  localparam int DEB     = 3;
  localparam int TIMEOUT = 1000;
  localparam int CNT_W   = 4;
  localparam int READY_T = HOLD + (STAGES - 1) * GAP;
  localparam int LOSS_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic [LOCK_W-1:0] lock;
  logic              sw_req;
  logic [STAGES-1:0] rst_out;
  logic              ready;
  logic              timeout;
  logic [CNT_W-1:0]  loss_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  reset_sequencer #(
    .LOCK_W(LOCK_W), .STAGES(STAGES), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
    .DEBOUNCE(DEB), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .lock(lock), .sw_req(sw_req),
    .rst_out(rst_out), .ready(ready), .timeout(timeout), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [STAGES-1:0] rst;
    logic             rdy;
    logic             to;
    logic [CNT_W-1:0] loss;
  } exp_t;

  exp_t exp_q[$];

  // Model: time since all PLLs were seen locked decides every release.
  logic [LOCK_W-1:0] m_s1, m_s2;
  bit m_in_seq;
  int m_t, m_low, m_loss, m_wait;
  bit m_to;

  function automatic bit m_ready();
    return m_in_seq && (m_t >= READY_T);
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    m_in_seq = 0; m_t = 0; m_low = 0; m_loss = 0; m_wait = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [LOCK_W-1:0] l, input logic s);
    bit al;
    al   = &m_s2;
    m_s2 = m_s1;
    m_s1 = l;
    if (!m_in_seq) begin
      if (al) begin
        m_in_seq = 1; m_t = 0; m_to = 0; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_to = 1;
      end
    end else if (m_t >= READY_T) begin
      m_low = al ? 0 : m_low + 1;
      if (m_low >= DEB) begin
        m_in_seq = 0; m_wait = 0; m_low = 0;
        if (m_loss < LOSS_MAX) m_loss++;
      end else if (s) begin
        m_t = 0; m_low = 0;
      end
    end else begin
      if (!al) begin
        m_in_seq = 0; m_wait = 0;
      end else if (s) begin
        m_t = 0;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic step(input logic [LOCK_W-1:0] l, input logic s);
    exp_t e;
    lock   = l;
    sw_req = s;
    @(posedge clk);
    cyc++;
    model_edge(l, s);
    e.cyc = cyc;
    for (int k = 0; k < STAGES; k++)
      e.rst[k] = !(m_in_seq && (m_t >= HOLD + k * GAP));
    e.rdy  = m_ready();
    e.to   = m_to;
    e.loss = CNT_W'(m_loss);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (rst_out !== e.rst || ready !== e.rdy || timeout !== e.to || loss_count !== e.loss) begin
        n_bad++;
        $display("FAIL cycle %0d: got rst_out=%b ready=%b timeout=%b loss=%0d, required rst_out=%b ready=%b timeout=%b loss=%0d",
                 e.cyc, rst_out, ready, timeout, loss_count, e.rst, e.rdy, e.to, e.loss);
      end
    end
  end

  task automatic check_reset_vals(input string name);
    n_cmp++;
    if (rst_out !== '1 || ready !== 1'b0 || timeout !== 1'b0 || loss_count !== '0) begin
      n_bad++;
      $display("FAIL %s: got rst_out=%b ready=%b timeout=%b loss=%0d, required all ones/0/0/0",
               name, rst_out, ready, timeout, loss_count);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_until_ready(input string name);
    int n;
    n = 0;
    while (!m_ready() && n < 200) begin
      step('1, 1'b0);
      n++;
    end
    n_cmp++;
    if (!m_ready()) begin
      n_bad++;
      $display("FAIL %s: not ready after %0d cycles, required ready", name, n);
    end
  endtask

  task automatic steps(input logic [LOCK_W-1:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    lock   = '0;
    sw_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    release_reset();
    $display("phase: reset released");

    steps('0, 5);
    run_until_ready("initial_release");
    steps('1, 4);
    $display("phase: initial release done");

    steps(2'b01, 2);
    steps('1, 6);
    steps(2'b01, 3);
    steps('1, 2);
    $display("phase: debounce glitch and loss done");

    steps('1, 20);
    steps(2'b10, 3);
    run_until_ready("relock_after_release_drop");
    $display("phase: drop during release done");

    steps(2'b01, TIMEOUT + 5);
    steps('1, 4);
    run_until_ready("after_timeout");
    $display("phase: timeout done");

    step(2'b10, 1'b0);
    step(2'b10, 1'b0);
    step(2'b10, 1'b0);
    step('1, 1'b0);
    step('1, 1'b1);
    step('1, 1'b0);
    run_until_ready("after_sw_vs_loss");
    $display("phase: sw_req against debounced loss done");

    step(2'b00, 1'b1);
    steps('1, 10);
    step('1, 1'b1);
    steps('1, 20);
    step('1, 1'b1);
    run_until_ready("after_sw_restarts");
    step('1, 1'b1);
    run_until_ready("after_sw_in_run");
    $display("phase: sw_req restarts done");

    for (int i = 0; i < 20; i++) begin
      run_until_ready("forced_loss");
      steps(2'b00, 3);
      steps('1, 2);
    end
    $display("phase: 20 forced losses done, model loss=%0d", m_loss);

    for (int i = 0; i < 150; i++) begin
      int len;
      logic [LOCK_W-1:0] pat;
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, 5);
        pat = LOCK_W'($urandom_range(0, (1 << LOCK_W) - 2));
      end else begin
        len = $urandom_range(1, 40);
        pat = '1;
      end
      for (int j = 0; j < len; j++)
        step(pat, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end
    step('1, 1'b0);
    $display("phase: random traffic done");

    run_until_ready("before_mid_run_reset");
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #2;
    check_reset_vals("mid_run_reset_async");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("mid_run_reset_held");
    release_reset();
    steps('0, 3);
    run_until_ready("after_mid_run_reset");
    steps('1, 3);
    $display("phase: mid-run reset done");

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
